// File: rtl/i2s_defs.sv
// Shared I2S framing definitions, common to the I2S input and output paths.
// Slot width default, FSM state encodings and the LRCLK level for the left slot.
package i2s_defs;

    localparam int I2S_WIDTH = 24;
    localparam logic LR_LEFT = 1'b0;

    typedef enum logic [1:0] {
        ALIGN = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_t;

endpackage

// File: rtl/i2s_sync.sv
// Multi-flop synchroniser for one async pin; optionally outputs a 1-clk rising-edge pulse.
// Latency STAGES clks (level) or STAGES clks to the pulse cycle; no backpressure.
module i2s_sync #(
    parameter int STAGES   = 2,
    parameter bit RISE_DET = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    generate
        if (RISE_DET) begin : g_rise
            logic last;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    last <= 1'b0;
                end else begin
                    last <= chain[STAGES-1];
                end
            end

            assign q = chain[STAGES-1] & ~last;
        end else begin : g_level
            assign q = chain[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/i2s_in.sv
// I2S slave receiver: async SCLK/LRCLK/SDIN in, signed WIDTH-bit L/R pair out once per frame.
// Latency ~SYNC_STAGES+2 clks from the closing SCLK rise; no backpressure, valid is a 1-clk pulse.
module i2s_in
    import i2s_defs::*;
#(
    parameter int WIDTH       = I2S_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sclk,
    input  logic                    lrclk,
    input  logic                    sdin,
    output logic signed [WIDTH-1:0] l_data,
    output logic signed [WIDTH-1:0] r_data,
    output logic                    valid,
    output logic                    fmt_err
);

    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  FULL = CW'(WIDTH);

    logic rise;
    logic lr_s;
    logic sd_s;

    i2s_sync #(.STAGES(SYNC_STAGES), .RISE_DET(1'b1)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(sclk), .q(rise)
    );
    i2s_sync #(.STAGES(SYNC_STAGES), .RISE_DET(1'b0)) u_sync_lrclk (
        .clk(clk), .reset(reset), .d(lrclk), .q(lr_s)
    );
    i2s_sync #(.STAGES(SYNC_STAGES), .RISE_DET(1'b0)) u_sync_sdin (
        .clk(clk), .reset(reset), .d(sdin), .q(sd_s)
    );

    i2s_state_t       state;
    i2s_state_t       state_nxt;
    logic             lr_prev;
    logic [CW-1:0]    bitcnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] l_hold;

    logic             lr_edge;
    logic [WIDTH-1:0] sh_close;
    logic [CW-1:0]    cnt_close;
    logic [WIDTH-1:0] word;
    logic             load_l;
    logic             load_out;
    logic             slot_chk;

    assign lr_edge = rise && (lr_s != lr_prev);

    // The bit sampled on the closing rise still belongs to the old slot.
    always_comb begin
        sh_close  = shreg;
        cnt_close = FULL;
        if (bitcnt < FULL) begin
            sh_close  = {shreg[WIDTH-2:0], sd_s};
            cnt_close = bitcnt + CW'(1);
        end
    end

    assign word = sh_close << (FULL - cnt_close);

    always_comb begin
        state_nxt = state;
        load_l    = 1'b0;
        load_out  = 1'b0;
        slot_chk  = 1'b0;
        if (lr_edge) begin
            case (state)
                ALIGN: begin
                    if (lr_s == LR_LEFT) begin
                        state_nxt = LEFT;
                    end
                end
                LEFT: begin
                    load_l    = 1'b1;
                    slot_chk  = 1'b1;
                    state_nxt = RIGHT;
                end
                RIGHT: begin
                    load_out  = 1'b1;
                    slot_chk  = 1'b1;
                    state_nxt = LEFT;
                end
                default: state_nxt = ALIGN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ALIGN;
            lr_prev <= 1'b0;
            bitcnt  <= '0;
            shreg   <= '0;
            l_hold  <= '0;
            l_data  <= '0;
            r_data  <= '0;
            valid   <= 1'b0;
            fmt_err <= 1'b0;
        end else begin
            state <= state_nxt;
            valid <= load_out;
            if (rise) begin
                lr_prev <= lr_s;
                if (lr_edge) begin
                    bitcnt <= '0;
                    shreg  <= '0;
                end else if (bitcnt < FULL) begin
                    shreg  <= {shreg[WIDTH-2:0], sd_s};
                    bitcnt <= bitcnt + CW'(1);
                end
            end
            if (load_l) begin
                l_hold <= word;
            end
            if (load_out) begin
                l_data <= $signed(l_hold);
                r_data <= $signed(word);
            end
            if (slot_chk && (cnt_close < FULL)) begin
                fmt_err <= 1'b1;
            end
        end
    end

endmodule
